alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq_pkg.sv | 102 ++++++++++
 rtl/alu_ctrl_seq_if.sv | 32 +++
 rtl/alu_ctrl_seq_mdu_lat_counter.sv | 34 +++
 rtl/alu_ctrl_seq.sv | 97 +++++++++
 tb/tb_alu_ctrl_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_pkg
// Brief   : ALU-control encodings, op/funct codes, FSM state type and decoder.
//           Define ALU_CTRL_DIV_EN to decode funct 011010 as a multi-cycle DIV.
// Revision: 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [3:0] c_selAdd  = 4'b0000;
    localparam logic [3:0] c_selSub  = 4'b0001;
    localparam logic [3:0] c_selSrl  = 4'b0010;
    localparam logic [3:0] c_selJr   = 4'b0011;
    localparam logic [3:0] c_selAnd  = 4'b0100;
    localparam logic [3:0] c_selOr   = 4'b0101;
    localparam logic [3:0] c_selSlt  = 4'b0110;
    localparam logic [3:0] c_selSll  = 4'b0111;
    localparam logic [3:0] c_selMult = 4'b1000;
    localparam logic [3:0] c_selDiv  = 4'b1001;
    localparam logic [3:0] c_selMfhi = 4'b1010;
    localparam logic [3:0] c_selMflo = 4'b1011;

    localparam logic [2:0] c_opRType = 3'b000;
    localparam logic [2:0] c_opOr    = 3'b001;
    localparam logic [2:0] c_opAddA  = 3'b010;
    localparam logic [2:0] c_opAddB  = 3'b011;
    localparam logic [2:0] c_opSub   = 3'b100;
    localparam logic [2:0] c_opJr    = 3'b101;
    localparam logic [2:0] c_opAnd   = 3'b110;
    localparam logic [2:0] c_opSlt   = 3'b111;

    localparam logic [5:0] c_fnAdd  = 6'b100000;
    localparam logic [5:0] c_fnSub  = 6'b100010;
    localparam logic [5:0] c_fnSrl  = 6'b000010;
    localparam logic [5:0] c_fnJr   = 6'b001000;
    localparam logic [5:0] c_fnAnd  = 6'b100100;
    localparam logic [5:0] c_fnOr   = 6'b100101;
    localparam logic [5:0] c_fnSlt  = 6'b101010;
    localparam logic [5:0] c_fnSll  = 6'b000000;
    localparam logic [5:0] c_fnMult = 6'b011000;
    localparam logic [5:0] c_fnDiv  = 6'b011010;
    localparam logic [5:0] c_fnMfhi = 6'b010000;
    localparam logic [5:0] c_fnMflo = 6'b010010;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic       ill;
        logic       multi;
    } decode_t;

    function automatic decode_t decodeOp(input logic [2:0] aluOP, input logic [5:0] funct);
        decode_t d;
        d.sel   = c_selAdd;
        d.ill   = 1'b0;
        d.multi = 1'b0;
        case (aluOP)
            c_opRType: begin
                case (funct)
                    c_fnAdd:  d.sel = c_selAdd;
                    c_fnSub:  d.sel = c_selSub;
                    c_fnSrl:  d.sel = c_selSrl;
                    c_fnJr:   d.sel = c_selJr;
                    c_fnAnd:  d.sel = c_selAnd;
                    c_fnOr:   d.sel = c_selOr;
                    c_fnSlt:  d.sel = c_selSlt;
                    c_fnSll:  d.sel = c_selSll;
                    c_fnMfhi: d.sel = c_selMfhi;
                    c_fnMflo: d.sel = c_selMflo;
                    c_fnMult: begin
                        d.sel   = c_selMult;
                        d.multi = 1'b1;
                    end
`ifdef ALU_CTRL_DIV_EN
                    c_fnDiv: begin
                        d.sel   = c_selDiv;
                        d.multi = 1'b1;
                    end
`else
                    c_fnDiv:  d.ill = 1'b1;
`endif
                    default:  d.ill = 1'b1;
                endcase
            end
            c_opOr:             d.sel = c_selOr;
            c_opAddA, c_opAddB: d.sel = c_selAdd;
            c_opSub:            d.sel = c_selSub;
            c_opJr:             d.sel = c_selJr;
            c_opAnd:            d.sel = c_selAnd;
            c_opSlt:            d.sel = c_selSlt;
            default:            d.sel = c_selAdd;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_seq_if
// Brief   : Instruction/result bundle between the issuing stage (master) and
//           the ALU-control sequencer (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface alu_ctrl_seq_if #(
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic [5:0]       funct;
    logic [2:0]       aluOP;
    logic             in_ready;
    logic [SEL_W-1:0] aluSel;
    logic             out_valid;
    logic             ill_op;
    logic             mdu_start;
    logic             mdu_done;
    logic             stall;

    modport master (
        output in_valid, funct, aluOP,
        input  in_ready, aluSel, out_valid, ill_op, mdu_start, mdu_done, stall
    );

    modport slave (
        input  in_valid, funct, aluOP,
        output in_ready, aluSel, out_valid, ill_op, mdu_start, mdu_done, stall
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_seq_mdu_lat_counter.sv
`default_nettype none
// ============================================================================
// Module  : mdu_lat_counter
// Brief   : Down-counter timing a multi-cycle op; loads MDU_LAT-1, flags zero.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_lat_counter #(
    parameter int MDU_LAT = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_dec,
    output logic      o_zero
);
    localparam int CNT_W = $clog2(MDU_LAT + 1);
    localparam logic [CNT_W-1:0] c_loadVal = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_zero = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_seq
// Brief   : Registered ALU-control decoder with a multi-cycle MULT/DIV sequencer.
//           ALU_CTRL_DIV_EN (see alu_ctrl_pkg) enables DIV decoding.
// Revision: 1.0 - initial release
// ============================================================================
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int MDU_LAT = 32
) (
    input wire logic      clk,
    input wire logic      rst,
    alu_ctrl_seq_if.slave bus
);
    state_t           r_state;
    logic [SEL_W-1:0] r_aluSel;
    logic             r_outValid;
    logic             r_illOp;
    logic             r_mduStart;
    logic             r_mduDone;

    decode_t w_dec;
    logic    w_ready;
    logic    w_accept;
    logic    w_load;
    logic    w_countDown;
    logic    w_cntZero;

    // Ready is a pure function of the state so the handshake never depends on inputs.
    assign w_ready     = (r_state != MDU_RUN);
    assign w_accept    = bus.in_valid & w_ready;
    assign w_dec       = decodeOp(bus.aluOP, bus.funct);
    assign w_load      = w_accept & w_dec.multi;
    assign w_countDown = (r_state == MDU_RUN) & ~w_cntZero;

    mdu_lat_counter #(
        .MDU_LAT (MDU_LAT)
    ) u_latCnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_countDown),
        .o_zero (w_cntZero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_aluSel   <= '0;
            r_outValid <= 1'b0;
            r_illOp    <= 1'b0;
            r_mduStart <= 1'b0;
            r_mduDone  <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            r_illOp    <= 1'b0;
            r_mduStart <= 1'b0;
            r_mduDone  <= 1'b0;
            case (r_state)
                MDU_RUN: begin
                    if (w_cntZero) begin
                        r_state    <= MDU_DONE;
                        r_outValid <= 1'b1;
                        r_mduDone  <= 1'b1;
                    end
                end
                // The completion cycle accepts exactly like IDLE, giving back-to-back issue.
                IDLE, MDU_DONE: begin
                    r_state <= IDLE;
                    if (w_accept) begin
                        r_aluSel <= SEL_W'(w_dec.sel);
                        if (w_dec.multi) begin
                            r_state    <= MDU_RUN;
                            r_mduStart <= 1'b1;
                        end else begin
                            r_outValid <= 1'b1;
                            r_illOp    <= w_dec.ill;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.stall     = ~w_ready;
    assign bus.aluSel    = r_aluSel;
    assign bus.out_valid = r_outValid;
    assign bus.ill_op    = r_illOp;
    assign bus.mdu_start = r_mduStart;
    assign bus.mdu_done  = r_mduDone;
endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_ctrl_seq
// Brief   : Directed self-checking bench for alu_ctrl_seq (MDU_LAT=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;
    localparam int SEL_W   = 4;
    localparam int MDU_LAT = 4;

    typedef struct {
        logic [3:0] sel;
        logic       ill;
        logic       mdu;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] sel;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_ctrl_seq_if #(.SEL_W(SEL_W)) bus ();

    alu_ctrl_seq #(
        .SEL_W   (SEL_W),
        .MDU_LAT (MDU_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction for one cycle and record its expected completion.
    task automatic send(input logic [2:0] op, input logic [5:0] fn,
                        input logic [3:0] sel, input logic ill, input logic mdu);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.aluOP    = op;
        bus.funct    = fn;
        e.sel = sel;
        e.ill = ill;
        e.mdu = mdu;
        e.cyc = cyc + (mdu ? 1 + MDU_LAT : 1);
        q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("aluSel", 32'(bus.aluSel), 32'(e.sel));
                    chk("ill_op", 32'(bus.ill_op), 32'(e.ill));
                    chk("mdu_done", 32'(bus.mdu_done), 32'(e.mdu));
                end
            end else begin
                chk("mdu_done_idle", 32'(bus.mdu_done), 32'd0);
            end
        end
    end

    vec_t vecs[$];

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.aluOP    = 3'b000;
        bus.funct    = 6'b000000;
        repeat (2) @(negedge clk);
        chk("rst_aluSel", 32'(bus.aluSel), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mdu_start", 32'(bus.mdu_start), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back single-cycle ops, aluOP classes then every R-type funct.
        vecs = '{
            '{3'b000, 6'b100010, 4'b0001, 1'b0}, '{3'b110, 6'b000000, 4'b0100, 1'b0},
            '{3'b101, 6'b000000, 4'b0011, 1'b0}, '{3'b011, 6'b111111, 4'b0000, 1'b0},
            '{3'b010, 6'b000000, 4'b0000, 1'b0}, '{3'b001, 6'b000000, 4'b0101, 1'b0},
            '{3'b100, 6'b000000, 4'b0001, 1'b0}, '{3'b111, 6'b000000, 4'b0110, 1'b0},
            '{3'b000, 6'b100000, 4'b0000, 1'b0}, '{3'b000, 6'b000010, 4'b0010, 1'b0},
            '{3'b000, 6'b001000, 4'b0011, 1'b0}, '{3'b000, 6'b100100, 4'b0100, 1'b0},
            '{3'b000, 6'b100101, 4'b0101, 1'b0}, '{3'b000, 6'b101010, 4'b0110, 1'b0},
            '{3'b000, 6'b000000, 4'b0111, 1'b0}, '{3'b000, 6'b010000, 4'b1010, 1'b0},
            '{3'b000, 6'b010010, 4'b1011, 1'b0}, '{3'b000, 6'b111111, 4'b0000, 1'b1},
            '{3'b000, 6'b100101, 4'b0101, 1'b0}
        };
        foreach (vecs[i]) send(vecs[i].op, vecs[i].fn, vecs[i].sel, vecs[i].ill, 1'b0);
        @(negedge clk);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_aluSel", 32'(bus.aluSel), 32'h5);

        // MULT with inputs presented while busy; they must be ignored.
        send(3'b000, 6'b011000, 4'b1000, 1'b0, 1'b1);
        chk("mult_start", 32'(bus.mdu_start), 32'd1);
        chk("mult_sel_early", 32'(bus.aluSel), 32'h8);
        bus.in_valid = 1'b1;
        bus.aluOP    = 3'b100;
        for (int i = 1; i <= MDU_LAT; i++) begin
            chk("run_stall", 32'(bus.stall), 32'd1);
            chk("run_in_ready", 32'(bus.in_ready), 32'd0);
            if (i > 1) chk("run_start_low", 32'(bus.mdu_start), 32'd0);
            @(negedge clk);
        end
        chk("done_stall", 32'(bus.stall), 32'd0);
        chk("done_in_ready", 32'(bus.in_ready), 32'd1);
        send(3'b010, 6'b000000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);

`ifdef ALU_CTRL_DIV_EN
        send(3'b000, 6'b011010, 4'b1001, 1'b0, 1'b1);
        chk("div_start", 32'(bus.mdu_start), 32'd1);
        repeat (MDU_LAT + 1) @(negedge clk);
`else
        send(3'b000, 6'b011010, 4'b0000, 1'b1, 1'b0);
        chk("div_no_start", 32'(bus.mdu_start), 32'd0);
        @(negedge clk);
`endif

        // Reset in the middle of a MULT aborts it without a completion.
        send(3'b000, 6'b011000, 4'b1000, 1'b0, 1'b1);
        @(negedge clk);
        q.delete();
        #2 rst = 1'b1;
        #1;
        chk("abort_aluSel", 32'(bus.aluSel), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_mdu_start", 32'(bus.mdu_start), 32'd0);
        chk("abort_mdu_done", 32'(bus.mdu_done), 32'd0);
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (MDU_LAT + 4) @(negedge clk);
        send(3'b111, 6'b000000, 4'b0110, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
